scmp_bus_ctl: RTL and testbench

Bus controller directly downstream of the scmp core. It consumes the core's external strobes (ADS_n, RD_n, WR_n), the 12-bit address and write data. It converts each strobe sequence into a single req/ack transaction on a synchronous memory port, inserts programmable wait states, and returns read data to the core's D_i input. It drives a hold signal that the core microcode uses to stall while a transaction is outstanding.

---
 rtl/scmp_bus_ctl.sv | 165 ++++++++++++++++
 tb/tb_scmp_bus_ctl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/scmp_bus_ctl.sv
// Bus controller behind the scmp core: turns ADS/RD/WR strobe sequences into one
// req/ack memory transaction with wait states, timeout abort and core hold.
module scmp_bus_ctl #(
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] addr,
  input  logic [7:0]  D_o,
  input  logic        ADS_n,
  input  logic        RD_n,
  input  logic        WR_n,
  output logic [7:0]  D_i,
  output logic        hold,
  output logic        bus_err,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_WAIT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [3:0] WS_LOAD  = 4'(WAIT_STATES);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic       HAS_WAIT = (WAIT_STATES > 0);

  state_t      state_r, state_nxt_s;
  logic [7:0]  tmo_cnt_r, tmo_cnt_nxt_s;
  logic [3:0]  ws_cnt_r, ws_cnt_nxt_s;
  logic [7:0]  d_i_nxt_s, mem_wdata_nxt_s;
  logic [11:0] mem_addr_nxt_s;
  logic        hold_nxt_s, bus_err_nxt_s, mem_we_nxt_s, mem_req_nxt_s;
  logic        ack_s, tmo_s, strb_rel_s;

  // Ack on the same edge as the last timeout cycle still counts as success.
  assign ack_s      = mem_req & mem_ack;
  assign tmo_s      = (tmo_cnt_r == TMO_LAST);
  assign strb_rel_s = RD_n & WR_n;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: if (!ADS_n) state_nxt_s = S_ADDR; else state_nxt_s = S_IDLE;
      S_ADDR: begin
        if (!ADS_n)     state_nxt_s = S_ADDR;
        else if (!RD_n) state_nxt_s = S_RD;
        else if (!WR_n) state_nxt_s = S_WR;
        else            state_nxt_s = S_ADDR;
      end
      S_RD, S_WR: begin
        if (ack_s)      state_nxt_s = HAS_WAIT ? S_WAIT : S_DONE;
        else if (tmo_s) state_nxt_s = S_DONE;
        else            state_nxt_s = state_r;
      end
      S_WAIT: if (ws_cnt_r <= 4'd1) state_nxt_s = S_DONE; else state_nxt_s = S_WAIT;
      // One strobe yields one transaction: wait for both strobes to release.
      S_DONE: begin
        if (strb_rel_s && !ADS_n) state_nxt_s = S_ADDR;
        else if (strb_rel_s)      state_nxt_s = S_IDLE;
        else                      state_nxt_s = S_DONE;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Next values of registered outputs and counters
  always_comb begin
    d_i_nxt_s       = D_i;
    hold_nxt_s      = hold;
    bus_err_nxt_s   = 1'b0;
    mem_addr_nxt_s  = mem_addr;
    mem_wdata_nxt_s = mem_wdata;
    mem_we_nxt_s    = mem_we;
    mem_req_nxt_s   = mem_req;
    tmo_cnt_nxt_s   = tmo_cnt_r;
    ws_cnt_nxt_s    = ws_cnt_r;
    case (state_r)
      S_IDLE: if (!ADS_n) mem_addr_nxt_s = addr; else mem_addr_nxt_s = mem_addr;
      S_ADDR: begin
        if (!ADS_n) begin
          mem_addr_nxt_s = addr;
        end else if (!RD_n) begin
          mem_req_nxt_s = 1'b1;
          mem_we_nxt_s  = 1'b0;
          hold_nxt_s    = 1'b1;
          tmo_cnt_nxt_s = 8'd0;
        end else if (!WR_n) begin
          mem_wdata_nxt_s = D_o;
          mem_req_nxt_s   = 1'b1;
          mem_we_nxt_s    = 1'b1;
          hold_nxt_s      = 1'b1;
          tmo_cnt_nxt_s   = 8'd0;
        end else begin
          mem_addr_nxt_s = mem_addr;
        end
      end
      S_RD, S_WR: begin
        if (ack_s) begin
          mem_req_nxt_s = 1'b0;
          ws_cnt_nxt_s  = WS_LOAD;
          if (state_r == S_RD) d_i_nxt_s = mem_rdata; else d_i_nxt_s = D_i;
        end else if (tmo_s) begin
          mem_req_nxt_s = 1'b0;
          bus_err_nxt_s = 1'b1;
          if (state_r == S_RD) d_i_nxt_s = 8'hFF; else d_i_nxt_s = D_i;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + 8'd1;
        end
      end
      S_WAIT: ws_cnt_nxt_s = ws_cnt_r - 4'd1;
      S_DONE: begin
        hold_nxt_s = 1'b0;
        if (strb_rel_s && !ADS_n) mem_addr_nxt_s = addr; else mem_addr_nxt_s = mem_addr;
      end
      default: hold_nxt_s = 1'b0;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D_i       <= 8'h00;
      hold      <= 1'b0;
      bus_err   <= 1'b0;
      mem_addr  <= 12'h000;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
      mem_req   <= 1'b0;
      tmo_cnt_r <= 8'd0;
      ws_cnt_r  <= 4'd0;
    end else begin
      D_i       <= d_i_nxt_s;
      hold      <= hold_nxt_s;
      bus_err   <= bus_err_nxt_s;
      mem_addr  <= mem_addr_nxt_s;
      mem_wdata <= mem_wdata_nxt_s;
      mem_we    <= mem_we_nxt_s;
      mem_req   <= mem_req_nxt_s;
      tmo_cnt_r <= tmo_cnt_nxt_s;
      ws_cnt_r  <= ws_cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_scmp_bus_ctl.sv
// Bench for scmp_bus_ctl: two instances (different wait/timeout settings) share
// one directed stimulus; expected waveforms come from a per-cycle timeline model.
module tb_scmp_bus_ctl;
  localparam int N  = 512;
  localparam int L  = 11;
  localparam int W0 = 0, T0 = 4, W1 = 2, T1 = 6;
  localparam int F_REQ = 0, F_HOLD = 1, F_ERR = 2, F_WE = 3, F_ADDR = 4, F_WDATA = 5, F_DI = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] addr;
  logic [7:0]  D_o;
  logic        ADS_n, RD_n, WR_n, mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  d_i [2];
  logic        hold [2], bus_err [2], mem_we [2], mem_req [2];
  logic [11:0] mem_addr [2];
  logic [7:0]  mem_wdata [2];

  scmp_bus_ctl #(.WAIT_STATES(W0), .TIMEOUT(T0)) dut_a (
    .clk(clk), .rst_n(rst_n), .addr(addr), .D_o(D_o), .ADS_n(ADS_n), .RD_n(RD_n), .WR_n(WR_n),
    .D_i(d_i[0]), .hold(hold[0]), .bus_err(bus_err[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]), .mem_req(mem_req[0]),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  scmp_bus_ctl #(.WAIT_STATES(W1), .TIMEOUT(T1)) dut_b (
    .clk(clk), .rst_n(rst_n), .addr(addr), .D_o(D_o), .ADS_n(ADS_n), .RD_n(RD_n), .WR_n(WR_n),
    .D_i(d_i[1]), .hold(hold[1]), .bus_err(bus_err[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]), .mem_req(mem_req[1]),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  // exp_v[inst][field][cycle]: value each output must show during that cycle.
  logic [11:0] exp_v [2][7][N];
  int cyc, n_pass, n_total;
  int hcnt [2], rcnt [2], ecnt [2];

  function automatic int par_w(int i); return (i == 0) ? W0 : W1; endfunction
  function automatic int par_t(int i); return (i == 0) ? T0 : T1; endfunction

  function automatic string fname(int f);
    case (f)
      F_REQ:   return "mem_req";
      F_HOLD:  return "hold";
      F_ERR:   return "bus_err";
      F_WE:    return "mem_we";
      F_ADDR:  return "mem_addr";
      F_WDATA: return "mem_wdata";
      default: return "D_i";
    endcase
  endfunction

  function automatic logic [11:0] act(int i, int f);
    case (f)
      F_REQ:   return {11'd0, mem_req[i]};
      F_HOLD:  return {11'd0, hold[i]};
      F_ERR:   return {11'd0, bus_err[i]};
      F_WE:    return {11'd0, mem_we[i]};
      F_ADDR:  return mem_addr[i];
      F_WDATA: return {4'd0, mem_wdata[i]};
      default: return {4'd0, d_i[i]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, want);
  endtask

  task automatic set_f(input int i, input int f, input int from, input int to, input logic [11:0] v);
    for (int k = from; k <= to && k < N; k++) exp_v[i][f][k] = v;
  endtask

  task automatic set_both(input int f, input int from, input logic [11:0] v);
    for (int i = 0; i < 2; i++) set_f(i, f, from, N - 1, v);
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      for (int f = 0; f < 7; f++)
        chk($sformatf("cyc%0d dut%0d %s", cyc, i, fname(f)), act(i, f), exp_v[i][f][cyc]);
      hcnt[i] += int'(hold[i]);
      rcnt[i] += int'(mem_req[i]);
      ecnt[i] += int'(bus_err[i]);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One strobe transaction; d = ack delay in cycles after entering RD/WR, -1 = never.
  task automatic txn(input int nads, input logic [11:0] a0, input logic [11:0] a1,
                     input bit rd, input bit wr, input logic [7:0] wd, input logic [7:0] rdat,
                     input int d, input bit chain, input logic [11:0] nxt);
    int s, e, w, t;
    for (int i = 0; i < 2; i++) begin hcnt[i] = 0; rcnt[i] = 0; ecnt[i] = 0; end
    if (nads == 2) begin ADS_n = 1'b0; addr = a0; set_both(F_ADDR, cyc + 1, a0); step(); end
    if (nads >= 1) begin ADS_n = 1'b0; addr = a1; set_both(F_ADDR, cyc + 1, a1); step(); end
    ADS_n = 1'b1; addr = 12'hDEF; RD_n = ~rd; WR_n = ~wr; D_o = wd;
    s = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      w = par_w(i); t = par_t(i);
      set_f(i, F_WE, s, N - 1, rd ? 12'd0 : 12'd1);
      if (!rd) set_f(i, F_WDATA, s, N - 1, {4'd0, wd});
      if (d >= 0 && d < t) begin
        e = s + d + 1;
        set_f(i, F_REQ, s, e - 1, 12'd1);
        if (rd) set_f(i, F_DI, e, N - 1, {4'd0, rdat});
        set_f(i, F_HOLD, s, e + w, 12'd1);
      end else begin
        e = s + t;
        set_f(i, F_REQ, s, e - 1, 12'd1);
        set_f(i, F_ERR, e, e, 12'd1);
        if (rd) set_f(i, F_DI, e, N - 1, 12'h0FF);
        set_f(i, F_HOLD, s, e, 12'd1);
      end
    end
    step();
    for (int j = 0; j < L; j++) begin
      mem_ack   = (j == d);
      mem_rdata = (j == d) ? rdat : 8'h0D;
      ADS_n     = (j == L - 2) ? 1'b0 : 1'b1;
      addr      = (j == L - 2) ? 12'hBAD : 12'hDEF;
      step();
    end
    mem_ack = 1'b0; mem_rdata = 8'h0D; RD_n = 1'b1; WR_n = 1'b1;
    ADS_n = ~chain; addr = chain ? nxt : 12'hDEF;
    if (chain) set_both(F_ADDR, cyc + 1, nxt);
    step();
    ADS_n = 1'b1; addr = 12'hDEF;
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0;
    for (int i = 0; i < 2; i++) begin
      hcnt[i] = 0; rcnt[i] = 0; ecnt[i] = 0;
      for (int f = 0; f < 7; f++) set_f(i, f, 0, N - 1, 12'd0);
    end
    rst_n = 1'b0; ADS_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1; mem_ack = 1'b0;
    addr = 12'hDEF; D_o = 8'h00; mem_rdata = 8'h0D;
    @(posedge clk); #1;
    step(); step();
    rst_n = 1'b1;
    step(); step();

    // Read, immediate ack
    txn(1, 12'h000, 12'h3A5, 1'b1, 1'b0, 8'h00, 8'h5C, 0, 1'b0, 12'h000);
    chk("rd0 hold cycles A", 12'(hcnt[0]), 12'd2);
    chk("rd0 hold cycles B", 12'(hcnt[1]), 12'd4);
    chk("rd0 req cycles A", 12'(rcnt[0]), 12'd1);
    chk("rd0 D_i A", {4'd0, d_i[0]}, 12'h05C);
    chk("rd0 addr A", mem_addr[0], 12'h3A5);

    // Write, ack delayed 3 cycles
    txn(1, 12'h000, 12'h0FF, 1'b0, 1'b1, 8'hA7, 8'h00, 3, 1'b0, 12'h000);
    chk("wr3 req cycles A", 12'(rcnt[0]), 12'd4);
    chk("wr3 hold cycles A", 12'(hcnt[0]), 12'd5);
    chk("wr3 wdata A", {4'd0, mem_wdata[0]}, 12'h0A7);
    chk("wr3 we A", {11'd0, mem_we[0]}, 12'd1);
    chk("wr3 D_i untouched A", {4'd0, d_i[0]}, 12'h05C);

    // Read, no ack: timeout abort
    txn(1, 12'h000, 12'h055, 1'b1, 1'b0, 8'h00, 8'h3C, -1, 1'b0, 12'h000);
    chk("tmo req cycles A", 12'(rcnt[0]), 12'd4);
    chk("tmo err cycles A", 12'(ecnt[0]), 12'd1);
    chk("tmo req cycles B", 12'(rcnt[1]), 12'd6);
    chk("tmo D_i A", {4'd0, d_i[0]}, 12'h0FF);

    // Read, ack on the last allowed cycle of A
    txn(1, 12'h000, 12'h066, 1'b1, 1'b0, 8'h00, 8'h96, 3, 1'b0, 12'h000);
    chk("ack@tmo err cycles A", 12'(ecnt[0]), 12'd0);
    chk("ack@tmo D_i A", {4'd0, d_i[0]}, 12'h096);

    // Two address strobes, then RD and WR together; release chains a new ADS
    txn(2, 12'h100, 12'h200, 1'b1, 1'b1, 8'h99, 8'h21, 1, 1'b1, 12'h7E1);
    chk("rdwr we A", {11'd0, mem_we[0]}, 12'd0);
    chk("rdwr D_i B", {4'd0, d_i[1]}, 12'h021);
    chk("chain addr A", mem_addr[0], 12'h7E1);

    // Write straight from the chained address phase
    txn(0, 12'h000, 12'h000, 1'b0, 1'b1, 8'h4B, 8'h00, 0, 1'b0, 12'h000);
    chk("chained wr wdata B", {4'd0, mem_wdata[1]}, 12'h04B);
    chk("chained wr addr B", mem_addr[1], 12'h7E1);

    // Strobes and ack with no prior address strobe are ignored
    RD_n = 1'b0; WR_n = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h5A;
    step(); step(); step();
    RD_n = 1'b1; WR_n = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h0D;
    step();
    chk("ignored D_i A", {4'd0, d_i[0]}, 12'h021);

    // Reset while a write is outstanding
    ADS_n = 1'b0; addr = 12'h321; set_both(F_ADDR, cyc + 1, 12'h321); step();
    ADS_n = 1'b1; addr = 12'hDEF; WR_n = 1'b0; D_o = 8'hE4;
    set_both(F_WE, cyc + 1, 12'd1); set_both(F_WDATA, cyc + 1, 12'h0E4);
    set_both(F_REQ, cyc + 1, 12'd1); set_both(F_HOLD, cyc + 1, 12'd1);
    step(); step();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("async rst mem_req dut%0d", i), {11'd0, mem_req[i]}, 12'd0);
      chk($sformatf("async rst hold dut%0d", i), {11'd0, hold[i]}, 12'd0);
      chk($sformatf("async rst mem_addr dut%0d", i), mem_addr[i], 12'h000);
    end
    for (int f = 0; f < 7; f++) set_both(f, cyc, 12'd0);
    WR_n = 1'b1;
    step();
    rst_n = 1'b1;
    step(); step();

    // Normal read after reset
    txn(1, 12'h000, 12'hABC, 1'b1, 1'b0, 8'h00, 8'hC3, 2, 1'b0, 12'h000);
    chk("post-rst D_i A", {4'd0, d_i[0]}, 12'h0C3);

    // Ack on cycle 5: past A's timeout, inside B's
    txn(1, 12'h000, 12'h123, 1'b1, 1'b0, 8'h00, 8'h77, 4, 1'b0, 12'h000);
    chk("split D_i A", {4'd0, d_i[0]}, 12'h0FF);
    chk("split D_i B", {4'd0, d_i[1]}, 12'h077);
    chk("split err cycles B", 12'(ecnt[1]), 12'd0);
    chk("split req cycles B", 12'(rcnt[1]), 12'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
